cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Memory-side responder for the icache/dcache request interface.
- Accepts instruction reads (iREN) and data reads/writes (dREN/dWEN) from the caches and serialises them onto a single-ported RAM with a ready handshake.
- Returns data and releases the matching wait line for exactly one cycle per completed access.
- Sits between the caches block and the RAM model/controller.

Parameters:
ADDR_W, 32, address width for cache and RAM sides
DATA_W, 32, data word width
TIMEOUT, 255, cycles in an access state without ram_ready before the access is aborted and flagged

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
iREN  in  1  icache read request, held until iwait is low
iaddr  in  ADDR_W  icache word address
iwait  out  1  0 for one cycle when the instruction access completes
iload  out  DATA_W  instruction data, valid when iwait=0
dREN  in  1  dcache read request
dWEN  in  1  dcache write request; wins over dREN if both are high
daddr  in  ADDR_W  dcache address
dstore  in  DATA_W  dcache write data
dwait  out  1  0 for one cycle when the data access completes
dload  out  DATA_W  read data, valid when dwait=0
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data, valid with ram_ready
ram_ready  in  1  RAM completes the current access this cycle
ram_err  out  1  sticky timeout flag, cleared only by RST

Behaviour:
- **Reset values:** state IDLE; iwait=1, dwait=1; ramREN=0, ramWEN=0; ramaddr, ramstore, iload and dload all 0; ram_err=0; last_grant=I, so data wins the first tie.
- **FSM states:** IDLE, IACC, DACC, RESP.
- **IDLE, arbitration:**
  - Only data pending (dREN|dWEN) -> DACC.
  - Only iREN pending -> IACC.
  - Both pending -> grant the side not equal to last_grant, i.e. round-robin on ties.
  - On the transition, latch the request into registers: addr, op (write if dWEN, else read), store data, owner.
  - Update last_grant to the owner.
- **IACC/DACC, access:**
  - Drive ramREN or ramWEN from the latched op, ramaddr from the latched addr, and ramstore from the latched store data (writes only).
  - Exactly one of ramREN/ramWEN is high in an access state; both are 0 in every other state.
  - Access cycle counter: clears on entry and increments each cycle.
  - ram_ready=1 -> capture ramload into a response register (reads only; writes keep the previous value), then go to RESP.
  - Counter reaches TIMEOUT-1 with no ready -> set ram_err, response data = 0, go to RESP.
- **RESP, response:**
  - Deassert the owner's wait (iwait=0 or dwait=0) for exactly one cycle.
  - iload/dload present the response register; they hold that value afterwards until the next completion for that side.
  - Return to IDLE next cycle.
  - Request inputs are not sampled in RESP, so the earliest next grant is the cycle after RESP.
- **Latency:**
  - Request high in IDLE at cycle 0 -> RAM enable high in cycles 1..k.
  - ram_ready in cycle k -> wait=0 in cycle k+1.
  - Minimum is 2 cycles from the request to wait=0.
- **Wait lines:** the non-owner wait is always 1. Both waits are never 0 in the same cycle.
- **Request dropped mid-access:** the RAM access still completes and RESP still pulses the owner's wait. The cache must ignore it.
- **Request inputs changing mid-access:** ignored. Only the values latched at grant are used.
- **RST asserted in any state:** the access is abandoned at that edge. All outputs return to reset values next cycle, including ram_err.
- **Widths:** addresses and data pass through unmodified with no byte-lane handling. The counter is wide enough to hold TIMEOUT (clog2(TIMEOUT+1) bits).

Test Plan:
- Reset: hold RST 2 cycles -> iwait=dwait=1, ramREN=ramWEN=0, iload=dload=0, ram_err=0.
- Instruction read: iREN=1, iaddr=0x40; RAM returns 0x8C220004 with ram_ready 3 cycles after ramREN rises -> ramaddr=0x40 for those 3 cycles; iwait=0 for one cycle the cycle after ready; iload=0x8C220004.
- Data write: dWEN=1, dREN=1, daddr=0x100, dstore=0xDEADBEEF, ready after 1 cycle -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait=0 exactly one cycle; iwait stays 1.
- Contention: iREN and dREN held from reset with instant ready -> grant order D, I, D, I; wait pulses alternate with no cycle where both waits are 0.
- Timeout: dREN=1, ram_ready tied 0, TIMEOUT=8 -> ramREN high for 8 cycles; ram_err=1 and stays 1; dwait=0 one cycle with dload=0; the next access proceeds normally.
- Mid-op reset: assert RST during DACC -> next cycle ramREN=0, dwait=1, state IDLE; a later iREN is served normally.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Serialises icache reads and dcache reads/writes onto a single-ported RAM.
// Each grant runs IDLE -> access -> RESP, and the owner's wait line drops for one cycle in RESP.
module cache_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ram_ready,
   output logic              ram_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] store_q, store_d;
   logic [DATA_W-1:0] resp_q, resp_d;
   logic [DATA_W-1:0] iload_q, iload_d;
   logic [DATA_W-1:0] dload_q, dload_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic              owner_q, owner_d;   // 1 = data side
   logic              last_q, last_d;     // 1 = data side granted last
   logic              err_q, err_d;
   logic              d_req;
   logic              grant_d;
   logic              in_acc;
   logic              i_resp;
   logic              d_resp;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         addr_q  <= '0;
         store_q <= '0;
         resp_q  <= '0;
         iload_q <= '0;
         dload_q <= '0;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         owner_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         store_q <= store_d;
         resp_q  <= resp_d;
         iload_q <= iload_d;
         dload_q <= dload_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      store_d = store_q;
      resp_d  = resp_q;
      iload_d = iload_q;
      dload_d = dload_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      owner_d = owner_q;
      last_d  = last_q;
      err_d   = err_q;
      d_req   = dREN | dWEN;
      grant_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (d_req || iREN) begin
               // On a tie the side that did not win last time is granted.
               grant_d = d_req && (!iREN || !last_q);
               owner_d = grant_d;
               last_d  = grant_d;
               addr_d  = grant_d ? daddr : iaddr;
               wr_d    = grant_d & dWEN;
               if (grant_d && dWEN) store_d = dstore;
               cnt_d   = '0;
               state_d = grant_d ? DACC : IACC;
            end
         end
         IACC, DACC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (ram_ready) begin
               if (!wr_q) resp_d = ramload;
               state_d = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               resp_d  = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            if (owner_q) dload_d = resp_q;
            else         iload_d = resp_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_acc   = (state_q == IACC) || (state_q == DACC);
   assign i_resp   = (state_q == RESP) && !owner_q;
   assign d_resp   = (state_q == RESP) && owner_q;
   assign ramREN   = in_acc & ~wr_q;
   assign ramWEN   = in_acc & wr_q;
   assign ramaddr  = addr_q;
   assign ramstore = store_q;
   assign iwait    = ~i_resp;
   assign dwait    = ~d_resp;
   assign iload    = i_resp ? resp_q : iload_q;
   assign dload    = d_resp ? resp_q : dload_q;
   assign ram_err  = err_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed vector table, randomized transactions against
// a transaction-level model, and hand-written contention, timeout and mid-access reset sequences.
module tb_cache_mem_arbiter;

   localparam int TIMEOUT = 8;

   logic        CLK;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic        ram_ready;
   logic        ram_err;

   int tests;
   int failed;

   // Transaction-level model: last response word and sticky error.
   logic [31:0] resp_m;
   logic        err_m;

   typedef struct {
      logic        is_d;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] store;
      logic [31:0] rdata;
      int          delay;
      logic [31:0] exp_load;
      logic        exp_err;
   } vec_t;

   vec_t vecs[5];

   cache_mem_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .iREN(iREN),
      .iaddr(iaddr),
      .iwait(iwait),
      .iload(iload),
      .dREN(dREN),
      .dWEN(dWEN),
      .daddr(daddr),
      .dstore(dstore),
      .dwait(dwait),
      .dload(dload),
      .ramREN(ramREN),
      .ramWEN(ramWEN),
      .ramaddr(ramaddr),
      .ramstore(ramstore),
      .ramload(ramload),
      .ram_ready(ram_ready),
      .ram_err(ram_err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   task automatic do_reset();
      RST = 1'b1;
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0;
      ram_ready = 1'b0; ramload = '0;
      @(posedge CLK);
      @(posedge CLK);
      #1 RST = 1'b0;
      resp_m = '0;
      err_m  = 1'b0;
   endtask

   // delay = enable cycle in which ram_ready is given (0 = never, forces a timeout).
   task automatic run_txn(input string name, input logic is_d, input logic wr,
                          input logic [31:0] addr, input logic [31:0] store,
                          input logic [31:0] rdata, input int delay,
                          input logic [31:0] exp_load, input logic exp_err);
      int c;
      int en_cnt;
      int bad;
      int exp_en;
      int done_c;
      exp_en = (delay == 0) ? TIMEOUT : delay;
      c = 0; en_cnt = 0; bad = 0; done_c = -1;
      @(posedge CLK);
      #1;
      if (is_d) begin
         dWEN = wr;
         dREN = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         daddr = addr;
         dstore = store;
      end else begin
         iREN = 1'b1;
         iaddr = addr;
      end
      while (done_c < 0 && c < 400) begin
         @(negedge CLK);
         if (ramREN || ramWEN) begin
            en_cnt++;
            if (ramREN === wr || ramWEN !== wr || ramaddr !== addr) bad++;
            if (wr && ramstore !== store) bad++;
         end
         if ((is_d ? iwait : dwait) !== 1'b1) bad++;
         if ((is_d ? dwait : iwait) === 1'b0) begin
            done_c = c;
            check({name, "_load"}, is_d ? dload : iload, exp_load);
            iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
         end
         ram_ready = (ramREN || ramWEN) && (en_cnt == delay);
         ramload = ram_ready ? rdata : $urandom;
         if (c >= 1 && done_c < 0) begin
            iaddr = $urandom; daddr = $urandom; dstore = $urandom;
         end
         c++;
      end
      if (done_c < 0) begin
         check({name, "_budget"}, 64'd0, 64'd1);
         iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      end else begin
         check({name, "_latency"}, 64'(done_c), 64'(exp_en + 1));
         check({name, "_en_cycles"}, 64'(en_cnt), 64'(exp_en));
         check({name, "_ram_side"}, 64'(bad), 64'd0);
         check({name, "_err"}, 64'(ram_err), 64'(exp_err));
         @(negedge CLK);
         check({name, "_pulse"}, 64'({iwait, dwait}), 64'd3);
      end
      ram_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] a, s, r, el;
      logic        is_d, wr;
      int          dl;
      logic        got_q[$];
      logic        exp_q[$];
      logic        last_m;
      int          both_low;
      int          n_en;

      tests = 0;
      failed = 0;

      vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h8C220004, 3, 32'h8C220004, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0,        1, 32'h8C220004, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h12345678, 2, 32'h12345678, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 32'h44,  32'h0,        32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 32'h104, 32'h0BADF00D, 32'h0,        4, 32'hA5A5A5A5, 1'b0};

      // Reset values
      do_reset();
      @(negedge CLK);
      check("rst_iwait", 64'(iwait), 64'd1);
      check("rst_dwait", 64'(dwait), 64'd1);
      check("rst_ramREN", 64'(ramREN), 64'd0);
      check("rst_ramWEN", 64'(ramWEN), 64'd0);
      check("rst_ramaddr", 64'(ramaddr), 64'd0);
      check("rst_ramstore", 64'(ramstore), 64'd0);
      check("rst_iload", 64'(iload), 64'd0);
      check("rst_dload", 64'(dload), 64'd0);
      check("rst_ram_err", 64'(ram_err), 64'd0);

      // Directed table
      for (int i = 0; i < 5; i++) begin
         run_txn($sformatf("vec%0d", i), vecs[i].is_d, vecs[i].wr, vecs[i].addr, vecs[i].store,
                 vecs[i].rdata, vecs[i].delay, vecs[i].exp_load, vecs[i].exp_err);
         if (!vecs[i].wr) resp_m = vecs[i].rdata;
      end
      check("hold_iload", 64'(iload), 64'hA5A5A5A5);
      check("hold_dload", 64'(dload), 64'hA5A5A5A5);

      // Randomized transactions against the model
      for (int i = 0; i < 30; i++) begin
         is_d = 1'($urandom_range(0, 1));
         wr   = is_d & 1'($urandom_range(0, 1));
         a    = $urandom;
         s    = $urandom;
         r    = $urandom;
         dl   = $urandom_range(1, 6);
         el   = wr ? resp_m : r;
         run_txn($sformatf("rnd%0d", i), is_d, wr, a, s, r, dl, el, err_m);
         resp_m = el;
      end

      // Contention from reset with instant ready
      do_reset();
      iREN = 1'b1; dREN = 1'b1; iaddr = 32'h10; daddr = 32'h20;
      both_low = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge CLK);
         if (!iwait && !dwait) both_low++;
         if (!dwait) got_q.push_back(1'b1);
         if (!iwait) got_q.push_back(1'b0);
         ram_ready = ramREN | ramWEN;
         ramload = ramaddr + 32'h1;
      end
      iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
      last_m = 1'b0;
      for (int k = 0; k < 8; k++) begin
         last_m = ~last_m;
         exp_q.push_back(last_m);
      end
      check("cont_both_low", 64'(both_low), 64'd0);
      check("cont_enough", 64'(got_q.size() >= 8), 64'd1);
      for (int k = 0; k < 8 && k < got_q.size(); k++)
         check($sformatf("cont_grant%0d", k), 64'(got_q[k]), 64'(exp_q[k]));
      check("cont_iload", 64'(iload), 64'h11);
      check("cont_dload", 64'(dload), 64'h21);

      // Timeout, then a normal access with the flag still set
      do_reset();
      run_txn("timeout", 1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 0, 32'h0, 1'b1);
      run_txn("after_to", 1'b0, 1'b0, 32'h50, 32'h0, 32'h77, 2, 32'h77, 1'b1);

      // Reset in the middle of a data access
      @(posedge CLK);
      #1 dREN = 1'b1; daddr = 32'h400;
      n_en = 0;
      for (int c = 0; c < 20 && n_en < 2; c++) begin
         @(negedge CLK);
         if (ramREN) n_en++;
      end
      check("midrst_started", 64'(n_en), 64'd2);
      RST = 1'b1; dREN = 1'b0;
      @(negedge CLK);
      check("midrst_ramREN", 64'(ramREN), 64'd0);
      check("midrst_dwait", 64'(dwait), 64'd1);
      check("midrst_iwait", 64'(iwait), 64'd1);
      check("midrst_ram_err", 64'(ram_err), 64'd0);
      RST = 1'b0;
      resp_m = '0; err_m = 1'b0;
      run_txn("post_rst", 1'b0, 1'b0, 32'h60, 32'h0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
